decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 190 +++++++++++++++++++
 tb/tb_decode_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: slices instruction fields, tracks pending GPR/FPR writes in
// per-file scoreboards and stalls upstream on read/write hazards.

module decode_hazard_lane #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0]      addr,
  input  logic [1:0]                 sel,
  input  logic [(1<<REG_ADDR_W)-1:0] pend_gpr,
  input  logic [(1<<REG_ADDR_W)-1:0] pend_fpr,
  input  logic                       held_vld,
  input  logic [1:0]                 held_dst,
  input  logic [REG_ADDR_W-1:0]      held_addr,
  output logic                       hit
);
  logic held_match;
  logic gpr_hit;
  logic fpr_hit;

  assign held_match = held_vld && (held_addr == addr);
  // r0 is hardwired, so it never carries a GPR dependency.
  assign gpr_hit = sel[0] && (addr != '0) && (pend_gpr[addr] || (held_match && held_dst[0]));
  assign fpr_hit = sel[1] && (pend_fpr[addr] || (held_match && held_dst[1]));
  assign hit     = gpr_hit || fpr_hit;
endmodule

module decode_stage #(
  parameter int INST_W      = 32,
  parameter int OPCODE_W    = 6,
  parameter int REG_ADDR_W  = 5,
  parameter int SHIFT_W     = 5,
  parameter int FUNCT_W     = 6,
  parameter int IMMEDIATE_W = 16,
  parameter int INDEX_W     = 26
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INST_W-1:0]      in_inst,
  input  logic [1:0]             in_s_use,
  input  logic [1:0]             in_t_use,
  input  logic [1:0]             in_d_use,
  input  logic [1:0]             in_d_dst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPCODE_W-1:0]    out_opcode,
  output logic [REG_ADDR_W-1:0]  out_rd_addr,
  output logic [REG_ADDR_W-1:0]  out_rs_addr,
  output logic [REG_ADDR_W-1:0]  out_rt_addr,
  output logic [SHIFT_W-1:0]     out_shift,
  output logic [FUNCT_W-1:0]     out_funct,
  output logic [IMMEDIATE_W-1:0] out_immediate,
  output logic [INDEX_W-1:0]     out_index,
  output logic [1:0]             out_d_dst,
  input  logic                   wb_valid,
  input  logic                   wb_fpr,
  input  logic [REG_ADDR_W-1:0]  wb_addr,
  input  logic                   flush,
  output logic [31:0]            stall_count
);
  localparam int NREG    = 1 << REG_ADDR_W;
  localparam int NUM_SRC = 4;
  localparam int OP_LSB  = INST_W - OPCODE_W;
  localparam int RD_LSB  = OP_LSB - REG_ADDR_W;
  localparam int RS_LSB  = RD_LSB - REG_ADDR_W;
  localparam int RT_LSB  = RS_LSB - REG_ADDR_W;
  localparam int SH_LSB  = RT_LSB - SHIFT_W;
  localparam int FN_LSB  = SH_LSB - FUNCT_W;

  typedef struct packed {
    logic [OPCODE_W-1:0]    opcode;
    logic [REG_ADDR_W-1:0]  rd;
    logic [REG_ADDR_W-1:0]  rs;
    logic [REG_ADDR_W-1:0]  rt;
    logic [SHIFT_W-1:0]     shift;
    logic [FUNCT_W-1:0]     funct;
    logic [IMMEDIATE_W-1:0] immediate;
    logic [INDEX_W-1:0]     index;
    logic [1:0]             d_dst;
  } dec_t;

  dec_t dec_d;
  dec_t dec_q;

  logic [NREG-1:0] pend_gpr;
  logic [NREG-1:0] pend_fpr;
  logic [NREG-1:0] clr_gpr;
  logic [NREG-1:0] clr_fpr;
  logic [NREG-1:0] set_gpr;
  logic [NREG-1:0] set_fpr;
  logic [NREG-1:0] byp_gpr;
  logic [NREG-1:0] byp_fpr;

  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_addr;
  logic [NUM_SRC-1:0][1:0]            src_sel;
  logic [NUM_SRC-1:0]                 src_hit;

  logic hazard;
  logic accept;
  logic handoff;

  always_comb begin
    dec_d           = '0;
    dec_d.opcode    = in_inst[OP_LSB +: OPCODE_W];
    dec_d.rd        = in_inst[RD_LSB +: REG_ADDR_W];
    dec_d.rs        = in_inst[RS_LSB +: REG_ADDR_W];
    dec_d.rt        = in_inst[RT_LSB +: REG_ADDR_W];
    dec_d.shift     = in_inst[SH_LSB +: SHIFT_W];
    dec_d.funct     = in_inst[FN_LSB +: FUNCT_W];
    dec_d.immediate = in_inst[IMMEDIATE_W-1:0];
    dec_d.index     = in_inst[INDEX_W-1:0];
    dec_d.d_dst     = in_d_dst;
  end

  // Sources checked in parallel: rs, rt, rd-as-source, rd-as-destination.
  assign src_addr = {dec_d.rd, dec_d.rd, dec_d.rt, dec_d.rs};
  assign src_sel  = {in_d_dst, in_d_use, in_t_use, in_s_use};

  always_comb begin
    clr_gpr = '0;
    clr_fpr = '0;
    set_gpr = '0;
    set_fpr = '0;
    if (wb_valid && !wb_fpr) clr_gpr[wb_addr] = 1'b1;
    if (wb_valid &&  wb_fpr) clr_fpr[wb_addr] = 1'b1;
    if (handoff && dec_q.d_dst[0] && (dec_q.rd != '0)) set_gpr[dec_q.rd] = 1'b1;
    if (handoff && dec_q.d_dst[1]) set_fpr[dec_q.rd] = 1'b1;
  end

  // Writeback clear is visible to this cycle's hazard check.
  assign byp_gpr = pend_gpr & ~clr_gpr;
  assign byp_fpr = pend_fpr & ~clr_fpr;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    decode_hazard_lane #(.REG_ADDR_W(REG_ADDR_W)) u_lane (
      .addr      (src_addr[i]),
      .sel       (src_sel[i]),
      .pend_gpr  (byp_gpr),
      .pend_fpr  (byp_fpr),
      .held_vld  (out_valid),
      .held_dst  (dec_q.d_dst),
      .held_addr (dec_q.rd),
      .hit       (src_hit[i])
    );
  end

  assign hazard   = |src_hit;
  assign in_ready = rstn && !hazard && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      dec_q     <= '0;
    end else begin
      if (flush)        out_valid <= 1'b0;
      else if (accept)  out_valid <= 1'b1;
      else if (handoff) out_valid <= 1'b0;
      if (accept) dec_q <= dec_d;
    end
  end

  // Set after clear so a same-cycle handoff beats a writeback to the same bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_gpr <= '0;
      pend_fpr <= '0;
    end else begin
      pend_gpr <= byp_gpr | set_gpr;
      pend_fpr <= byp_fpr | set_fpr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                       stall_count <= '0;
    else if (in_valid && hazard && stall_count != '1) stall_count <= stall_count + 32'd1;
  end

  assign out_opcode    = dec_q.opcode;
  assign out_rd_addr   = dec_q.rd;
  assign out_rs_addr   = dec_q.rs;
  assign out_rt_addr   = dec_q.rt;
  assign out_shift     = dec_q.shift;
  assign out_funct     = dec_q.funct;
  assign out_immediate = dec_q.immediate;
  assign out_index     = dec_q.index;
  assign out_d_dst     = dec_q.d_dst;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: rule-level model compared every cycle, plus
// hand-computed directed checks.

module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [1:0]  in_s_use = '0, in_t_use = '0, in_d_use = '0, in_d_dst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rd_addr, out_rs_addr, out_rt_addr, out_shift;
  logic [5:0]  out_funct;
  logic [15:0] out_immediate;
  logic [25:0] out_index;
  logic [1:0]  out_d_dst;
  logic        wb_valid = 1'b0, wb_fpr = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] stall_count;

  decode_stage dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_s_use(in_s_use), .in_t_use(in_t_use), .in_d_use(in_d_use), .in_d_dst(in_d_dst),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rd_addr(out_rd_addr), .out_rs_addr(out_rs_addr), .out_rt_addr(out_rt_addr),
    .out_shift(out_shift), .out_funct(out_funct), .out_immediate(out_immediate),
    .out_index(out_index), .out_d_dst(out_d_dst), .wb_valid(wb_valid), .wb_fpr(wb_fpr),
    .wb_addr(wb_addr), .flush(flush), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ho_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: pending sets per file, the held instruction, and a stall counter.
  logic [31:0] mg = '0, mf = '0;
  logic        m_ov = 1'b0;
  logic [31:0] m_inst = '0;
  logic [1:0]  m_dst = '0;
  logic [31:0] m_cnt = '0;

  function automatic logic m_hazard();
    logic [4:0] a [4];
    logic [1:0] s [4];
    logic       h;
    a = '{in_inst[20:16], in_inst[15:11], in_inst[25:21], in_inst[25:21]};
    s = '{in_s_use, in_t_use, in_d_use, in_d_dst};
    h = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int f = 0; f < 2; f++) begin
        if (s[i][f] && !(f == 0 && a[i] == 5'd0)) begin
          logic pend_now;
          pend_now = (f == 0) ? mg[a[i]] : mf[a[i]];
          if (wb_valid && (int'(wb_fpr) == f) && wb_addr == a[i]) pend_now = 1'b0;
          if (pend_now) h = 1'b1;
          if (m_ov && m_dst[f] && m_inst[25:21] == a[i]) h = 1'b1;
        end
      end
    end
    return h;
  endfunction

  function automatic logic m_ready();
    return rstn && !m_hazard() && !flush && (!m_ov || out_ready);
  endfunction

  always @(posedge clk) begin
    logic [31:0] ng, nf;
    logic acc, ho;
    cyc <= cyc + 1;
    if (!rstn) begin
      mg <= '0; mf <= '0; m_ov <= 1'b0; m_inst <= '0; m_dst <= '0; m_cnt <= '0;
    end else begin
      acc = in_valid && m_ready();
      ho  = m_ov && out_ready && !flush;
      if (in_valid && m_hazard() && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
      ng = mg; nf = mf;
      if (wb_valid && !wb_fpr) ng[wb_addr] = 1'b0;
      if (wb_valid &&  wb_fpr) nf[wb_addr] = 1'b0;
      if (ho && m_dst[0] && m_inst[25:21] != 5'd0) ng[m_inst[25:21]] = 1'b1;
      if (ho && m_dst[1]) nf[m_inst[25:21]] = 1'b1;
      mg <= ng; mf <= nf;
      if (flush)    m_ov <= 1'b0;
      else if (acc) m_ov <= 1'b1;
      else if (ho)  m_ov <= 1'b0;
      if (acc) begin m_inst <= in_inst; m_dst <= in_d_dst; end
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_stall", 64'(stall_count), 64'(0));
    end else begin
      chk("in_ready", 64'(in_ready), 64'(m_ready()));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        chk("fields", 64'({out_opcode, out_rd_addr, out_rs_addr, out_rt_addr, out_shift, out_funct, out_d_dst}),
            64'({m_inst[31:26], m_inst[25:21], m_inst[20:16], m_inst[15:11], m_inst[10:6], m_inst[5:0], m_dst}));
        chk("imm_index", 64'({out_immediate, out_index}), 64'({m_inst[15:0], m_inst[25:0]}));
      end
      chk("stall_count", 64'(stall_count), 64'(m_cnt));
      chk("pend_gpr", 64'(dut.pend_gpr), 64'(mg));
      chk("pend_fpr", 64'(dut.pend_fpr), 64'(mf));
      if (out_valid && out_ready && !flush) ho_q.push_back(cyc);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt);
    return {op[5:0], rd[4:0], rs[4:0], rt[4:0], 11'h0};
  endfunction

  task automatic put(input logic [31:0] inst, input logic [1:0] su, input logic [1:0] du,
                     input logic [1:0] dst);
    in_valid = 1'b1; in_inst = inst; in_s_use = su; in_t_use = 2'b00; in_d_use = du; in_d_dst = dst;
  endtask

  initial begin
    int start;
    step(2);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_stall", 64'(stall_count), 64'(0));
    rstn = 1'b1;

    // Field decode
    put(32'h04432A85, 2'b00, 2'b00, 2'b00);
    #1 chk("ready_after_reset", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    #1;
    chk("dec_valid", 64'(out_valid), 64'(1));
    chk("dec_opc_rd_rs_rt", 64'({out_opcode, out_rd_addr, out_rs_addr, out_rt_addr}),
        64'({6'd1, 5'd2, 5'd3, 5'd5}));
    chk("dec_shift_funct", 64'({out_shift, out_funct}), 64'({5'd10, 6'd5}));
    chk("dec_immediate", 64'(out_immediate), 64'(16'h2A85));
    chk("dec_index", 64'(out_index), 64'(26'h0432A85));
    out_ready = 1'b1;
    step();

    // RAW stall on GPR r2, released by same-cycle writeback
    put(mk(0, 2, 0, 0), 2'b00, 2'b00, 2'b01);
    step();
    put(mk(0, 0, 2, 0), 2'b01, 2'b00, 2'b00);
    step(3);
    #1;
    chk("raw_ready_low", 64'(in_ready), 64'(0));
    chk("raw_stall3", 64'(stall_count), 64'(3));
    wb_valid = 1'b1; wb_addr = 5'd2; wb_fpr = 1'b0;
    #1 chk("raw_wb_bypass", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0; wb_valid = 1'b0;
    chk("raw_stall_held", 64'(stall_count), 64'(3));

    // File separation: FPR r2 pending does not block GPR r2
    put(mk(0, 2, 0, 0), 2'b00, 2'b00, 2'b10);
    step();
    put(mk(0, 0, 2, 0), 2'b01, 2'b00, 2'b00);
    #1 chk("sep_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    step();
    chk("sep_pend_fpr2", 64'(dut.pend_fpr[2]), 64'(1));
    chk("sep_no_stall", 64'(stall_count), 64'(3));
    wb_valid = 1'b1; wb_fpr = 1'b1; wb_addr = 5'd2;
    step();
    wb_valid = 1'b0; wb_fpr = 1'b0;
    step();

    // Back-to-back
    start = ho_q.size();
    for (int i = 0; i < 4; i++) begin
      put(mk(i + 1, 10 + i, 20 + i, 0), 2'b00, 2'b00, 2'b00);
      step();
    end
    in_valid = 1'b0;
    step(2);
    chk("b2b_count", 64'(ho_q.size() - start), 64'(4));
    if (ho_q.size() - start >= 4)
      chk("b2b_consecutive", 64'(ho_q[start + 3] - ho_q[start]), 64'(3));

    // Flush of held GPR write to r7
    out_ready = 1'b0;
    put(mk(0, 7, 0, 0), 2'b00, 2'b00, 2'b01);
    step();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    #1 chk("flush_ready_low", 64'(in_ready), 64'(0));
    step();
    flush = 1'b0;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_pend7", 64'(dut.pend_gpr[7]), 64'(0));
    put(mk(0, 0, 7, 0), 2'b01, 2'b00, 2'b00);
    #1 chk("flush_reader_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    step();

    // Set beats same-cycle clear; rd-as-source hazard
    put(mk(0, 4, 0, 0), 2'b00, 2'b00, 2'b01);
    step();
    in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd4;
    step();
    wb_valid = 1'b0;
    #1 chk("set_wins", 64'(dut.pend_gpr[4]), 64'(1));
    put(mk(0, 4, 0, 0), 2'b00, 2'b01, 2'b00);
    #1 chk("rd_use_hazard", 64'(in_ready), 64'(0));
    wb_valid = 1'b1;
    #1 chk("rd_use_released", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0; wb_valid = 1'b0;
    step();

    // Reset with held instruction and three pending bits
    put(mk(0, 1, 0, 0), 2'b00, 2'b00, 2'b01); step();
    put(mk(0, 3, 0, 0), 2'b00, 2'b00, 2'b01); step();
    put(mk(0, 5, 0, 0), 2'b00, 2'b00, 2'b01); step();
    put(mk(9, 0, 0, 0), 2'b00, 2'b00, 2'b00); step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("pre_rst_pend", 64'({dut.pend_gpr[1], dut.pend_gpr[3], dut.pend_gpr[5]}), 64'(3'b111));
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rstn = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'(0));
    chk("async_pend_gpr", 64'(dut.pend_gpr), 64'(0));
    chk("async_pend_fpr", 64'(dut.pend_fpr), 64'(0));
    chk("async_stall", 64'(stall_count), 64'(0));
    chk("async_in_ready", 64'(in_ready), 64'(0));
    chk("async_opcode", 64'(out_opcode), 64'(0));
    step(2);
    rstn = 1'b1;
    step();

    // Mixed traffic on a small register range, checked by the model
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_inst   = mk($urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3)) | ($urandom() & 32'h7FF);
      in_s_use  = 2'($urandom_range(0, 3));
      in_t_use  = 2'($urandom_range(0, 3));
      in_d_use  = 2'($urandom_range(0, 3));
      in_d_dst  = 2'($urandom_range(0, 2));
      out_ready = 1'($urandom_range(0, 1));
      wb_valid  = 1'($urandom_range(0, 1));
      wb_fpr    = 1'($urandom_range(0, 1));
      wb_addr   = 5'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
